// File: rtl/mlaccel_mspi.sv
// ---------------------------------------------------------------------------
// mlaccel_mspi -- oversampled SPI slave front end for the accelerator command
// path. Every SPI pin is synchronised into the system clock domain. The block
// supports 1/2/4 data lanes and all four CPOL/CPHA modes, and feeds MISO from
// a small transmit FIFO with underrun reporting.
//
// Optional feature macro: MLACCEL_MSPI_CRC_EN adds an 8-bit CRC output
// (CRC-8, poly 0x07, init 0x00, MSB first) over the bytes of the frame.
//
// Ports:
//   clock, resetn          system clock (>= 4x spi_clk), async active-low reset
//   spi_csb, spi_clk       chip select (active low) and SPI clock
//   spi_di[LANES]          MOSI lanes, lane LANES-1 is the MSB
//   spi_do[LANES], spi_oe  MISO lanes and their output enable (= active)
//   active                 synchronised frame-active flag
//   din_valid/start/data   received byte stream (one-cycle pulse, no backpressure)
//   dout_valid/ready/data  transmit byte stream into the FIFO
//   dout_underrun          one-cycle pulse when FILL was loaded
//   crc                    running frame CRC (only with MLACCEL_MSPI_CRC_EN)
// ---------------------------------------------------------------------------
module mlaccel_mspi #(
    parameter int          LANES       = 1,
    parameter int          CPOL        = 0,
    parameter int          CPHA        = 0,
    parameter int          SYNC_STAGES = 2,
    parameter int          DOUT_DEPTH  = 4,
    parameter logic [7:0]  FILL        = 8'hFF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             spi_csb,
    input  logic             spi_clk,
    input  logic [LANES-1:0] spi_di,
    output logic [LANES-1:0] spi_do,
    output logic             spi_oe,
    output logic             active,
    output logic             din_valid,
    output logic             din_start,
    output logic [7:0]       din_data,
    input  logic             dout_valid,
    output logic             dout_ready,
    input  logic [7:0]       dout_data,
`ifdef MLACCEL_MSPI_CRC_EN
    output logic [7:0]       crc,
`endif
    output logic             dout_underrun
);

    localparam logic CLK_IDLE   = (CPOL != 0);
    localparam int   AW         = $clog2(DOUT_DEPTH);
    localparam int   CW         = AW + 1;
    localparam logic [2:0] LAST_CNT = 3'(8 - LANES);

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    // ---------------- synchronisers ----------------
    logic [SYNC_STAGES-1:0] csb_sync, clk_sync;
    logic [LANES-1:0]       di_sync [SYNC_STAGES];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            csb_sync <= '1;
            clk_sync <= {SYNC_STAGES{CLK_IDLE}};
            for (int i = 0; i < SYNC_STAGES; i++) di_sync[i] <= '0;
        end else begin
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            di_sync[0] <= spi_di;
            for (int i = 1; i < SYNC_STAGES; i++) di_sync[i] <= di_sync[i-1];
        end
    end

    logic             csb_s, clk_s, clk_d;
    logic [LANES-1:0] di_s;
    assign csb_s = csb_sync[SYNC_STAGES-1];
    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign di_s  = di_sync[SYNC_STAGES-1];

    assign active = !csb_s;
    assign spi_oe = active;

    // ---------------- frame FSM ----------------
    state_t state, state_nxt;
    logic   frame_start, frame_end;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE:  if (!csb_s) begin state_nxt = ST_FRAME; frame_start = 1'b1; end
            ST_FRAME: if (csb_s)  begin state_nxt = ST_IDLE;  frame_end   = 1'b1; end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- edge detection ----------------
    // The delayed copy is forced to the idle level at frame start, so clock
    // activity while deselected never produces an edge inside the frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          clk_d <= CLK_IDLE;
        else if (frame_start) clk_d <= CLK_IDLE;
        else                  clk_d <= clk_s;
    end

    logic in_frame, lead_edge, trail_edge, sample_edge, shift_edge;
    assign in_frame    = (state == ST_FRAME) && !csb_s;
    assign lead_edge   = in_frame && (clk_d == CLK_IDLE) && (clk_s != CLK_IDLE);
    assign trail_edge  = in_frame && (clk_d != CLK_IDLE) && (clk_s == CLK_IDLE);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge  : trail_edge;

    // ---------------- transmit FIFO ----------------
    logic [7:0]    mem [DOUT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ready_en, fifo_full, fifo_empty, push, pop;
    logic [2:0]    bit_cnt;
    logic          byte_done, load;

    assign fifo_full  = (count == CW'(DOUT_DEPTH));
    assign fifo_empty = (count == '0);
    // ready_en keeps dout_ready low while in reset and one cycle after.
    assign dout_ready = ready_en && !fifo_full;
    assign push       = dout_valid && dout_ready;
    assign byte_done  = sample_edge && (bit_cnt == LAST_CNT);
    assign load       = frame_start || byte_done;
    assign pop        = load && !fifo_empty;

    // NOTE: the storage array has no reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= dout_data;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (frame_end) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef MLACCEL_MSPI_CRC_EN
    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction
`endif

    // ---------------- shift registers ----------------
    logic [7:0] rx, tx, rx_next;
    logic       first;
    assign rx_next = {rx[7-LANES:0], di_s};
    assign spi_do  = active ? tx[7 -: LANES] : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rx            <= '0;
            tx            <= '0;
            bit_cnt       <= '0;
            first         <= 1'b0;
            ready_en      <= 1'b0;
            din_valid     <= 1'b0;
            din_start     <= 1'b0;
            din_data      <= '0;
            dout_underrun <= 1'b0;
`ifdef MLACCEL_MSPI_CRC_EN
            crc           <= '0;
`endif
        end else begin
            ready_en      <= 1'b1;
            din_valid     <= 1'b0;
            dout_underrun <= 1'b0;
            if (frame_start) begin
                first   <= 1'b1;
                bit_cnt <= '0;
                rx      <= '0;
`ifdef MLACCEL_MSPI_CRC_EN
                crc     <= '0;
`endif
            end else if (frame_end) begin
                bit_cnt <= '0;
                rx      <= '0;
                tx      <= '0;
            end else if (sample_edge) begin
                rx      <= rx_next;
                bit_cnt <= bit_cnt + 3'(LANES);
                if (byte_done) begin
                    din_valid <= 1'b1;
                    din_data  <= rx_next;
                    din_start <= first;
                    first     <= 1'b0;
`ifdef MLACCEL_MSPI_CRC_EN
                    crc       <= crc8_byte(crc, rx_next);
`endif
                end
            end else if (shift_edge && bit_cnt != '0) begin
                // A shift edge at bit 0 directly follows a load; skipping it
                // keeps the freshly loaded MSB on the wire for the master.
                tx <= tx << LANES;
            end
            if (load) begin
                tx            <= fifo_empty ? FILL : mem[rd_ptr];
                dout_underrun <= fifo_empty;
            end
        end
    end

endmodule

// File: tb/tb_mlaccel_mspi.sv
// ---------------------------------------------------------------------------
// tb_mlaccel_mspi -- directed bench for mlaccel_mspi. Instance u0 is LANES=1,
// mode 0; instance u3 is LANES=4, mode 3. Both share clock and resetn.
// ---------------------------------------------------------------------------
module tb_mlaccel_mspi;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    // u0 pins
    logic       csb0 = 1'b1, sclk0 = 1'b0, di0 = 1'b0;
    logic       do0, oe0, act0, dv0, ds0, or0, ur0;
    logic [7:0] dd0;
    logic       ov0 = 1'b0;
    logic [7:0] od0 = 8'h00;
    // u3 pins
    logic       csb3 = 1'b1, sclk3 = 1'b1;
    logic [3:0] di3 = 4'h0;
    logic [3:0] do3;
    logic       oe3, act3, dv3, ds3, or3, ur3;
    logic [7:0] dd3;
    logic       ov3 = 1'b0;
    logic [7:0] od3 = 8'h00;
`ifdef MLACCEL_MSPI_CRC_EN
    logic [7:0] crc0, crc3;
`endif

    mlaccel_mspi #(.LANES(1), .CPOL(0), .CPHA(0), .SYNC_STAGES(2), .DOUT_DEPTH(4), .FILL(8'hFF)) u0 (
        .clock(clock), .resetn(resetn), .spi_csb(csb0), .spi_clk(sclk0), .spi_di(di0),
        .spi_do(do0), .spi_oe(oe0), .active(act0), .din_valid(dv0), .din_start(ds0),
        .din_data(dd0), .dout_valid(ov0), .dout_ready(or0), .dout_data(od0),
`ifdef MLACCEL_MSPI_CRC_EN
        .crc(crc0),
`endif
        .dout_underrun(ur0)
    );

    mlaccel_mspi #(.LANES(4), .CPOL(1), .CPHA(1), .SYNC_STAGES(2), .DOUT_DEPTH(4), .FILL(8'hFF)) u3 (
        .clock(clock), .resetn(resetn), .spi_csb(csb3), .spi_clk(sclk3), .spi_di(di3),
        .spi_do(do3), .spi_oe(oe3), .active(act3), .din_valid(dv3), .din_start(ds3),
        .din_data(dd3), .dout_valid(ov3), .dout_ready(or3), .dout_data(od3),
`ifdef MLACCEL_MSPI_CRC_EN
        .crc(crc3),
`endif
        .dout_underrun(ur3)
    );

    int total = 0;
    int bad   = 0;

    // Passive monitors: received bytes as {start, data} and underrun pulses.
    logic [8:0] q0[$];
    logic [8:0] q3[$];
    int ur_cnt0 = 0;
    int ur_cnt3 = 0;
    always @(negedge clock) begin
        if (dv0) q0.push_back({ds0, dd0});
        if (dv3) q3.push_back({ds3, dd3});
        if (ur0) ur_cnt0++;
        if (ur3) ur_cnt3++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- master helpers (u0: mode 0, u3: mode 3) ----------------
    task automatic push0(input logic [7:0] b);
        ov0 = 1'b1; od0 = b;
        @(negedge clock);
        ov0 = 1'b0;
    endtask

    task automatic frame_start0();
        csb0 = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic frame_end0();
        repeat (4) @(negedge clock);
        csb0 = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic bit0(input logic b, output logic m);
        di0 = b;
        repeat (4) @(negedge clock);
        m = do0;
        sclk0 = 1'b1;
        repeat (8) @(negedge clock);
        sclk0 = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic byte0(input logic [7:0] mosi, output logic [7:0] miso);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            bit0(mosi[i], m);
            miso[i] = m;
        end
    endtask

    task automatic nib3(input logic [3:0] mosi, output logic [3:0] miso);
        sclk3 = 1'b0;
        di3 = mosi;
        repeat (8) @(negedge clock);
        miso = do3;
        sclk3 = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++; if (act0 !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", act0); end
        total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", oe0); end
        total++; if (do0 !== 1'b0) begin bad++; $display("FAIL reset_do got=%b want=0", do0); end
        total++; if (dv0 !== 1'b0 || ds0 !== 1'b0) begin bad++; $display("FAIL reset_din got=%b%b want=00", dv0, ds0); end
        total++; if (dd0 !== 8'h00) begin bad++; $display("FAIL reset_din_data got=%h want=00", dd0); end
        total++; if (or0 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", or0); end
        total++; if (ur0 !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", ur0); end
        total++; if (do3 !== 4'h0 || act3 !== 1'b0) begin bad++; $display("FAIL reset_u3 got=%h/%b want=0/0", do3, act3); end
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (or0 !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", or0); end
        total++; if (act0 !== 1'b0) begin bad++; $display("FAIL post_reset_active got=%b want=0", act0); end
    endtask

    task automatic test_mode0();
        int qi = q0.size();
        int u  = ur_cnt0;
        logic [7:0] m1, m2;
        logic [8:0] e0, e1;
        push0(8'h3C);
        frame_start0();
        total++; if (act0 !== 1'b1 || oe0 !== 1'b1) begin bad++; $display("FAIL m0_active got=%b%b want=11", act0, oe0); end
        byte0(8'h20, m1);
        byte0(8'hA5, m2);
        frame_end0();
        e0 = (q0.size() > qi)     ? q0[qi]     : 9'h1FF;
        e1 = (q0.size() > qi + 1) ? q0[qi + 1] : 9'h1FF;
        total++; if (q0.size() != qi + 2) begin bad++; $display("FAIL m0_din_count got=%0d want=%0d", q0.size() - qi, 2); end
        total++; if (e0 !== {1'b1, 8'h20}) begin bad++; $display("FAIL m0_byte0 got=%h want=120", e0); end
        total++; if (e1 !== {1'b0, 8'hA5}) begin bad++; $display("FAIL m0_byte1 got=%h want=0a5", e1); end
        total++; if (m1 !== 8'h3C) begin bad++; $display("FAIL m0_miso0 got=%h want=3c", m1); end
        total++; if (m2 !== 8'hFF) begin bad++; $display("FAIL m0_miso1 got=%h want=ff", m2); end
        total++; if (ur_cnt0 - u != 2) begin bad++; $display("FAIL m0_underruns got=%0d want=2", ur_cnt0 - u); end
        total++; if (dd0 !== 8'hA5 || ds0 !== 1'b0) begin bad++; $display("FAIL m0_hold got=%b/%h want=0/a5", ds0, dd0); end
        total++; if (act0 !== 1'b0 || do0 !== 1'b0) begin bad++; $display("FAIL m0_idle got=%b/%b want=0/0", act0, do0); end
    endtask

    task automatic test_lanes4_mode3();
        int qi = q3.size();
        int u  = ur_cnt3;
        logic [3:0] n1, n2;
        logic [8:0] e0;
        ov3 = 1'b1; od3 = 8'h81;
        @(negedge clock);
        ov3 = 1'b0;
        csb3 = 1'b0;
        repeat (8) @(negedge clock);
        nib3(4'h2, n1);
        nib3(4'h5, n2);
        repeat (4) @(negedge clock);
        csb3 = 1'b1;
        repeat (8) @(negedge clock);
        e0 = (q3.size() > qi) ? q3[qi] : 9'h1FF;
        total++; if (q3.size() != qi + 1) begin bad++; $display("FAIL l4_din_count got=%0d want=1", q3.size() - qi); end
        total++; if (e0 !== {1'b1, 8'h25}) begin bad++; $display("FAIL l4_byte got=%h want=125", e0); end
        total++; if (n1 !== 4'h8) begin bad++; $display("FAIL l4_miso_hi got=%h want=8", n1); end
        total++; if (n2 !== 4'h1) begin bad++; $display("FAIL l4_miso_lo got=%h want=1", n2); end
        total++; if (ur_cnt3 - u != 1) begin bad++; $display("FAIL l4_underruns got=%0d want=1", ur_cnt3 - u); end
        total++; if (do3 !== 4'h0) begin bad++; $display("FAIL l4_idle_do got=%h want=0", do3); end
    endtask

    task automatic test_abort();
        int qi;
        logic m;
        logic [7:0] mb;
        logic [8:0] e0;
        push0(8'hAA);
        push0(8'hBB);
        qi = q0.size();
        frame_start0();
        for (int i = 0; i < 5; i++) bit0(1'b1, m);
        frame_end0();
        total++; if (q0.size() != qi) begin bad++; $display("FAIL abort_no_din got=%0d want=0", q0.size() - qi); end
        total++; if (or0 !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", or0); end
        total++; if (do0 !== 1'b0) begin bad++; $display("FAIL abort_do got=%b want=0", do0); end
        frame_start0();
        byte0(8'h5A, mb);
        frame_end0();
        e0 = (q0.size() > qi) ? q0[qi] : 9'h1FF;
        total++; if (e0 !== {1'b1, 8'h5A}) begin bad++; $display("FAIL abort_next_byte got=%h want=15a", e0); end
        total++; if (mb !== 8'hFF) begin bad++; $display("FAIL abort_flushed got=%h want=ff", mb); end
    endtask

    task automatic test_fifo_full();
        int n = 0;
        int qi;
        logic [7:0] mb;
        for (int k = 1; k <= 4; k++) begin
            total++; if (or0 !== 1'b1) begin bad++; $display("FAIL full_ready_before_%0d got=%b want=1", k, or0); end
            od0 = 8'(k); ov0 = 1'b1;
            @(negedge clock);
        end
        total++; if (or0 !== 1'b0) begin bad++; $display("FAIL full_ready_after4 got=%b want=0", or0); end
        od0 = 8'h05;
        repeat (3) @(negedge clock);
        total++; if (or0 !== 1'b0) begin bad++; $display("FAIL full_fifth_held got=%b want=0", or0); end
        qi = q0.size();
        csb0 = 1'b0;
        while (or0 !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        ov0 = 1'b0;
        total++; if (or0 !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1 (timeout)", or0); end
        repeat (6) @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            byte0(8'(8'h10 + k), mb);
            total++; if (mb !== 8'(k)) begin bad++; $display("FAIL full_pop_%0d got=%h want=%h", k, mb, 8'(k)); end
        end
        frame_end0();
        total++; if (q0.size() != qi + 4) begin bad++; $display("FAIL full_din_count got=%0d want=4", q0.size() - qi); end
    endtask

    task automatic test_midreset();
        int qi;
        logic m;
        logic [7:0] mb;
        logic [8:0] e0;
        frame_start0();
        for (int i = 0; i < 3; i++) bit0(1'b1, m);
        #2 resetn = 1'b0;
        #1;
        total++; if (act0 !== 1'b0 || oe0 !== 1'b0) begin bad++; $display("FAIL mid_active got=%b%b want=00", act0, oe0); end
        total++; if (dd0 !== 8'h00 || ds0 !== 1'b0 || dv0 !== 1'b0) begin bad++; $display("FAIL mid_din got=%b%b/%h want=00/00", dv0, ds0, dd0); end
        total++; if (or0 !== 1'b0 || do0 !== 1'b0 || ur0 !== 1'b0) begin bad++; $display("FAIL mid_misc got=%b%b%b want=000", or0, do0, ur0); end
        csb0 = 1'b1;
        sclk0 = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        qi = q0.size();
        frame_start0();
        byte0(8'h26, mb);
        frame_end0();
        e0 = (q0.size() > qi) ? q0[qi] : 9'h1FF;
        total++; if (e0 !== {1'b1, 8'h26}) begin bad++; $display("FAIL mid_resume got=%h want=126", e0); end
        total++; if (mb !== 8'hFF) begin bad++; $display("FAIL mid_resume_miso got=%h want=ff", mb); end
    endtask

`ifdef MLACCEL_MSPI_CRC_EN
    task automatic test_crc();
        logic [7:0] mb;
        frame_start0();
        total++; if (crc0 !== 8'h00) begin bad++; $display("FAIL crc_clear0 got=%h want=00", crc0); end
        byte0(8'h01, mb);
        total++; if (crc0 !== 8'h07) begin bad++; $display("FAIL crc_byte1 got=%h want=07", crc0); end
        byte0(8'h02, mb);
        frame_end0();
        total++; if (crc0 !== 8'h1B) begin bad++; $display("FAIL crc_held got=%h want=1b", crc0); end
        frame_start0();
        total++; if (crc0 !== 8'h00) begin bad++; $display("FAIL crc_clear got=%h want=00", crc0); end
        frame_end0();
    endtask
`endif

    initial begin
        test_reset();
        test_mode0();
        test_lanes4_mode3();
        test_abort();
        test_fifo_full();
        test_midreset();
`ifdef MLACCEL_MSPI_CRC_EN
        test_crc();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
